// File: rtl/alu_seq_core_if.sv
// alu_seq_core_if: request/result bundle for the sequential ALU stage.
// The requester drives start/op/a/b. The ALU returns busy/done plus the
// registered result and flags that the Y register captures.
interface alu_seq_core_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALU;
    logic             carry;
    logic             zero;
    logic             ovf;

    modport master (
        output start, op, a, b,
        input  busy, done, ALU, carry, zero, ovf
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, ALU, carry, zero, ovf
    );
endinterface

// File: rtl/alu_seq_core.sv
// alu_seq_core: registered arithmetic/logic stage feeding the Y register.
// start/busy/done handshake. Single-cycle ops take one EXEC cycle.
// MUL is an iterative shift-add over WIDTH cycles.
// Optional feature macro: ALU_SEQ_OVF_EN enables signed-overflow detection
// on ADD/SUB. When it is not defined, ovf is tied to 0.
module alu_seq_core #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    alu_seq_core_if.slave      bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    state_t               state_r;
    logic [2:0]           op_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;        // operand B; also the multiplier, shifted right during MUL
    logic [2*WIDTH-1:0]   mcand_r;    // multiplicand, shifted left during MUL
    logic [2*WIDTH-1:0]   acc_r;      // product accumulator
    logic [CW-1:0]        cnt_r;      // MUL iteration 0..WIDTH-1
    logic                 busy_r;
    logic                 done_r;
    logic [WIDTH-1:0]     alu_r;
    logic                 carry_r;
    logic                 zero_r;

    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       diff_s;
    logic [WIDTH-1:0]     exec_res_s;
    logic                 exec_carry_s;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic                 mul_last_s;

`ifdef ALU_SEQ_OVF_EN
    logic                 ovf_r;
    logic                 exec_ovf_s;
`endif

    // Single-cycle op result: sum/difference carry into the extra MSB.
    always_comb begin
        sum_s        = {1'b0, a_r} + {1'b0, b_r};
        diff_s       = {1'b0, a_r} - {1'b0, b_r};
        exec_res_s   = {WIDTH{1'b0}};
        exec_carry_s = 1'b0;
        case (op_r)
            OP_ADD: begin
                exec_res_s   = sum_s[WIDTH-1:0];
                exec_carry_s = sum_s[WIDTH];
            end
            OP_SUB: begin
                exec_res_s   = diff_s[WIDTH-1:0];
                exec_carry_s = diff_s[WIDTH];
            end
            OP_AND: begin
                exec_res_s   = a_r & b_r;
                exec_carry_s = 1'b0;
            end
            OP_OR: begin
                exec_res_s   = a_r | b_r;
                exec_carry_s = 1'b0;
            end
            OP_XOR: begin
                exec_res_s   = a_r ^ b_r;
                exec_carry_s = 1'b0;
            end
            OP_NOT: begin
                exec_res_s   = ~a_r;
                exec_carry_s = 1'b0;
            end
            OP_SHL: begin
                exec_res_s   = {a_r[WIDTH-2:0], 1'b0};
                exec_carry_s = a_r[WIDTH-1];
            end
            default: begin
                // MUL never reaches EXEC; it finishes from the MUL state.
                exec_res_s   = {WIDTH{1'b0}};
                exec_carry_s = 1'b0;
            end
        endcase
    end

`ifdef ALU_SEQ_OVF_EN
    // Signed overflow: ADD with like signs, or SUB with unlike signs, flips the sign of A.
    always_comb begin
        exec_ovf_s = 1'b0;
        if (op_r == OP_ADD) begin
            exec_ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                         (sum_s[WIDTH-1] != a_r[WIDTH-1]);
        end else if (op_r == OP_SUB) begin
            exec_ovf_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                         (diff_s[WIDTH-1] != a_r[WIDTH-1]);
        end else begin
            exec_ovf_s = 1'b0;
        end
    end
`endif

    // One shift-add step: add the multiplicand when the multiplier LSB is set.
    always_comb begin
        if (b_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
        mul_last_s = (cnt_r == CW'(WIDTH - 1));
    end

    // Control FSM with operand latching and registered result/flag outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            op_r    <= 3'b000;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            mcand_r <= {(2*WIDTH){1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            alu_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            zero_r  <= 1'b1;
`ifdef ALU_SEQ_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        op_r    <= bus.op;
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        mcand_r <= {{WIDTH{1'b0}}, bus.a};
                        acc_r   <= {(2*WIDTH){1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= (bus.op == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    alu_r   <= exec_res_s;
                    carry_r <= exec_carry_s;
                    zero_r  <= (exec_res_s == {WIDTH{1'b0}});
`ifdef ALU_SEQ_OVF_EN
                    ovf_r   <= exec_ovf_s;
`endif
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                MUL: begin
                    acc_r   <= acc_next_s;
                    mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    if (mul_last_s) begin
                        // Any bit above the low half of the product means it did not fit.
                        alu_r   <= acc_next_s[WIDTH-1:0];
                        carry_r <= |acc_next_s[2*WIDTH-1:WIDTH];
                        zero_r  <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
`ifdef ALU_SEQ_OVF_EN
                        ovf_r   <= 1'b0;
`endif
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.ALU   = alu_r;
    assign bus.carry = carry_r;
    assign bus.zero  = zero_r;
`ifdef ALU_SEQ_OVF_EN
    assign bus.ovf   = ovf_r;
`else
    assign bus.ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: randomized stimulus checked every cycle against a
// behavioural model, plus hand-computed literal expectations.
module tb_alu_seq_core;

    localparam int W = 4;
    localparam int M = 1 << W;
    localparam int H = M / 2;

    logic clk;
    logic reset;

    alu_seq_core_if #(.WIDTH(W)) bus ();

    alu_seq_core #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= H) ? v - M : v;
    endfunction

    function automatic int f_res(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % M;
            1: return (a - b + M) % M;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (M - 1) - a;
            6: return (a * 2) % M;
            default: return (a * b) % M;
        endcase
    endfunction

    function automatic int f_carry(input int op, input int a, input int b);
        case (op)
            0: return (a + b >= M) ? 1 : 0;
            1: return (a < b) ? 1 : 0;
            6: return (a >= H) ? 1 : 0;
            7: return (a * b >= M) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int f_ovf(input int op, input int a, input int b);
        int s;
`ifdef ALU_SEQ_OVF_EN
        if (op == 0) begin
            s = sgn(a) + sgn(b);
            return (s > H - 1 || s < -H) ? 1 : 0;
        end else if (op == 1) begin
            s = sgn(a) - sgn(b);
            return (s > H - 1 || s < -H) ? 1 : 0;
        end
`endif
        s = 0;
        return s;
    endfunction

    // Behavioural model: an accepted request completes after a fixed number of edges.
    int m_busy, m_done, m_alu, m_carry, m_zero, m_ovf, m_left;
    int m_res, m_c, m_o;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 0;
            m_done  <= 0;
            m_alu   <= 0;
            m_carry <= 0;
            m_zero  <= 1;
            m_ovf   <= 0;
            m_left  <= 0;
        end else begin
            m_done <= 0;
            if (m_busy == 0) begin
                if (bus.start) begin
                    m_res  <= f_res(int'(bus.op), int'(bus.a), int'(bus.b));
                    m_c    <= f_carry(int'(bus.op), int'(bus.a), int'(bus.b));
                    m_o    <= f_ovf(int'(bus.op), int'(bus.a), int'(bus.b));
                    m_left <= (bus.op == 3'd7) ? W : 1;
                    m_busy <= 1;
                end
            end else if (m_left == 1) begin
                m_alu   <= m_res;
                m_carry <= m_c;
                m_zero  <= (m_res == 0) ? 1 : 0;
                m_ovf   <= m_o;
                m_done  <= 1;
                m_busy  <= 0;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("busy",  int'(bus.busy),  m_busy);
        chk("done",  int'(bus.done),  m_done);
        chk("alu",   int'(bus.ALU),   m_alu);
        chk("carry", int'(bus.carry), m_carry);
        chk("zero",  int'(bus.zero),  m_zero);
        chk("ovf",   int'(bus.ovf),   m_ovf);
    end

    task automatic issue(input int op, input int a, input int b);
        bus.start = 1'b1;
        bus.op    = 3'(op);
        bus.a     = W'(a);
        bus.b     = W'(b);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    // Called at a negedge k0 edges after the start edge; returns in the done cycle.
    task automatic wait_done(input int exp_lat, input int k0, input string nm);
        int k;
        bit seen;
        k = k0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            if (bus.done) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no done within %0d edges, required %0d", nm, k, exp_lat);
        end else begin
            chk({nm, "_latency"}, k, exp_lat);
        end
    endtask

    task automatic lit(input string nm, input int alu, input int carry, input int zero);
        chk({nm, "_alu"},   int'(bus.ALU),   alu);
        chk({nm, "_carry"}, int'(bus.carry), carry);
        chk({nm, "_zero"},  int'(bus.zero),  zero);
    endtask

    task automatic count_done(input int cycles, input string nm);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        chk(nm, pulses, 0);
    endtask

    initial begin
        int op, gap;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        lit("reset", 0, 0, 1);
        chk("reset_busy", int'(bus.busy), 0);
        #1 reset = 1'b0;

        // ADD 9+8: -7 + -8 overflows in 4-bit signed
        @(negedge clk);
        issue(0, 9, 8);
        wait_done(2, 1, "add");
        lit("add", 1, 1, 0);
`ifdef ALU_SEQ_OVF_EN
        chk("add_ovf", int'(bus.ovf), 1);
`else
        chk("add_ovf", int'(bus.ovf), 0);
`endif

        // SUB 3-3 then back-to-back SUB 2-5 from the done cycle
        @(negedge clk);
        issue(1, 3, 3);
        wait_done(2, 1, "sub0");
        lit("sub0", 0, 0, 1);
        issue(1, 2, 5);
        wait_done(2, 1, "sub1");
        lit("sub1", 13, 1, 0);

        // MUL 3*5 and 7*9
        @(negedge clk);
        issue(7, 3, 5);
        wait_done(W + 1, 1, "mul0");
        lit("mul0", 15, 0, 0);
        @(negedge clk);
        issue(7, 7, 9);
        wait_done(W + 1, 1, "mul1");
        lit("mul1", 15, 1, 0);

        // start during MUL is ignored
        @(negedge clk);
        issue(7, 3, 5);
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 4'd1;
        bus.b     = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(W + 1, 2, "mul_ign");
        lit("mul_ign", 15, 0, 0);
        count_done(6, "mul_ign_extra_done");

        // start during EXEC is ignored
        issue(0, 2, 3);
        bus.start = 1'b1;
        bus.op    = 3'd6;
        bus.a     = 4'd15;
        bus.b     = 4'd15;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(2, 2, "exec_ign");
        lit("exec_ign", 5, 0, 0);
        count_done(4, "exec_ign_extra_done");

        // SHL1 and NOT
        issue(6, 8, 0);
        wait_done(2, 1, "shl");
        lit("shl", 0, 1, 1);
        @(negedge clk);
        issue(5, 5, 0);
        wait_done(2, 1, "not");
        lit("not", 10, 0, 0);

        // asynchronous reset two cycles into MUL 7*9
        @(negedge clk);
        issue(7, 7, 9);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_done", int'(bus.done), 0);
        lit("rst_mid", 0, 0, 1);
        @(negedge clk);
        #1 reset = 1'b0;
        count_done(8, "rst_mid_no_done");
        issue(0, 1, 2);
        wait_done(2, 1, "after_rst");
        lit("after_rst", 3, 0, 0);

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 150; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            op = $urandom_range(0, 7);
            issue(op, $urandom_range(0, M - 1), $urandom_range(0, M - 1));
            wait_done((op == 7) ? W + 1 : 2, 1, "rand");
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Registered arithmetic/logic stage directly upstream of the Y result register.
- Accepts two operands and an opcode under a start/busy/done handshake, then computes the result.
- Most ops finish in one execute cycle; multiply is iterative shift-add over WIDTH cycles.
- Drives the 4-bit ALU result bus and flags that the Y register captures.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  3  opcode, latched with start
- a  input  WIDTH  operand A, latched with start
- b  input  WIDTH  operand B, latched with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when ALU/flags are updated
- ALU  output  WIDTH  registered result; holds until the next done
- carry  output  1  carry/borrow/shift-out/multiply-overflow
- zero  output  1  high when ALU == 0
- ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, ALU=0, carry=0, zero=1, ovf=0. All internal operand, accumulator and count registers are cleared.
- Reset mid-operation aborts immediately. No done pulse is produced. ALU is cleared.
- FSM states: IDLE, EXEC, MUL.
- IDLE, start=1 at a clock edge:
  - latch a, b and op;
  - busy<=1;
  - next state is MUL if op=111, otherwise EXEC.
- start is ignored whenever state != IDLE. No queuing.
- EXEC, one cycle. At the edge leaving EXEC, the result is registered into ALU/carry/zero/ovf, done<=1, busy<=0, state<=IDLE.
- Op encoding (all arithmetic modulo 2^WIDTH):
  - 000 ADD: ALU=A+B; carry=carry-out.
  - 001 SUB: ALU=A-B; carry=borrow (1 when A<B unsigned).
  - 010 AND; 011 OR; 100 XOR: carry=0.
  - 101 NOT A: carry=0.
  - 110 SHL1: ALU=A<<1; carry=A[WIDTH-1].
  - 111 MUL: unsigned product, low WIDTH bits to ALU; carry=1 if any upper product bit is nonzero.
- MUL:
  - Accumulator is 2*WIDTH bits. Iteration counter runs 0..WIDTH-1.
  - Each cycle: if the multiplier LSB=1, add the shifted multiplicand; shift the multiplier right and the multiplicand left.
  - After exactly WIDTH MUL cycles, the finishing edge registers the result, pulses done and returns to IDLE.
  - MUL latency: WIDTH+1 edges from the start-sampling edge to done.
- Single-cycle op latency: 2 edges from the start-sampling edge to done (start edge, then EXEC edge).
- done is high for exactly one cycle. During the done cycle the state is already IDLE, so a start in that cycle is accepted (back-to-back throughput).
- zero is derived from the registered ALU value and updates together with done.
- ALU, carry, zero and ovf are stable between done pulses. Downstream may sample them at any time.
- Changes on a/b/op after the start edge have no effect on the operation in flight.
- Illegal/unused encodings: none; all 8 opcodes are defined.

Optional Feature:
- Macro: ALU_SEQ_OVF_EN.
- Defined:
  - ovf is set on ADD when both operands have the same sign and the result sign differs.
  - ovf is set on SUB when the operand signs differ and the result sign differs from A.
  - ovf=0 for all other ops.
  - ovf is updated with done.
- Undefined: ovf is constant 0 and no overflow logic is synthesized. The port is still present.

Test Plan:
- reset asserted mid-MUL (a=7, b=9, 2 cycles in), asynchronously -> busy=0, ALU=0, zero=1 immediately; no done pulse; next start is accepted normally.
- ADD a=9, b=8 -> done 2 edges after start; ALU=1, carry=1, zero=0; with ALU_SEQ_OVF_EN, ovf=1 (-7 + -8).
- SUB a=3, b=3, then back-to-back SUB a=2, b=5 with start held in the done cycle -> first ALU=0, zero=1, carry=0; second done 2 edges later with ALU=13, carry=1.
- MUL a=3, b=5 -> busy for 4 cycles, done at edge 5; ALU=15, carry=0. Then MUL a=7, b=9 -> ALU=15 (63 mod 16), carry=1.
- start pulsed during EXEC/MUL with different operands -> ignored; the result matches the original operands; exactly one done pulse.
- SHL1 a=1000b -> ALU=0000b, carry=1, zero=1. NOT a=0101b -> ALU=1010b, carry=0.
